// File: rtl/mem_access_unit.sv
// Load/store front-end for the data RAM: byte/half/word accesses, big-endian lanes, RMW for sub-word stores.
// Optional build macro MAU_RANGE_CHECK_EN rejects addresses beyond the RAM instead of aliasing them.
module mem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w,
    output logic              ram_r,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

    state_t      state_r;
    logic [1:0]  off_r;
    logic [1:0]  size_r;
    logic        sext_r;
    logic        we_r;
    logic [15:0] wdata_r;
    logic        misalign_s;
    logic        range_bad_s;
    logic        bad_s;
    logic        unused_s;

    // Select the addressed lane (offset 0 = MSB byte) and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half lane of a word, leaving the other lanes intact.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] sz, input logic [15:0] data);
        logic [31:0] r;
        r = word;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = data[7:0];
                    2'd1:    r[23:16] = data[7:0];
                    2'd2:    r[15:8]  = data[7:0];
                    default: r[7:0]   = data[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[15:0] = data;
                end else begin
                    r[31:16] = data;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Alignment and legality of the request presented for acceptance.
    always_comb begin
        misalign_s = 1'b0;
        case (size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = addr[0];
            2'b10:   misalign_s = |addr[1:0];
            default: misalign_s = 1'b1;
        endcase
    end

`ifdef MAU_RANGE_CHECK_EN
    assign range_bad_s = |addr[31:ADDR_W+2];
    assign unused_s    = 1'b0;
`else
    assign range_bad_s = 1'b0;
    assign unused_s    = ^addr[31:ADDR_W+2];
`endif

    assign bad_s = misalign_s | range_bad_s;

    // Access sequencer; every RAM-side and handshake output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_w     <= 1'b0;
            ram_r     <= 1'b0;
            ram_wdata <= 32'd0;
            off_r     <= 2'd0;
            size_r    <= 2'd0;
            sext_r    <= 1'b0;
            we_r      <= 1'b0;
            wdata_r   <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        off_r   <= addr[1:0];
                        size_r  <= size;
                        sext_r  <= sign_ext;
                        we_r    <= we;
                        wdata_r <= wdata[15:0];
                        rdata   <= 32'd0;
                        ready   <= 1'b0;
                        if (bad_s) begin
                            state_r <= FIN;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            ram_addr <= addr[ADDR_W+1:2];
                            if (we && (size == 2'b10)) begin
                                state_r   <= WR;
                                ram_w     <= 1'b1;
                                ram_wdata <= wdata;
                            end else begin
                                state_r <= RD;
                                ram_r   <= 1'b1;
                            end
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                RD: begin
                    ram_r <= 1'b0;
                    if (we_r) begin
                        ram_wdata <= store_merge(ram_rdata, off_r, size_r, wdata_r);
                        ram_w     <= 1'b1;
                        state_r   <= WR;
                    end else begin
                        rdata   <= load_extract(ram_rdata, off_r, size_r, sext_r);
                        done    <= 1'b1;
                        state_r <= FIN;
                    end
                end
                WR: begin
                    ram_w   <= 1'b0;
                    done    <= 1'b1;
                    state_r <= FIN;
                end
                FIN: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    ram_w   <= 1'b0;
                    ram_r   <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random traffic against a byte-array model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready, done, err, ram_w, ram_r;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic [6:0]  ram_addr;

    logic [31:0] mem [0:127];
    logic [7:0]  ref_b [0:511];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata;
    int          done_seen;

    mem_access_unit #(.ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
        .ram_addr(ram_addr), .ram_w(ram_w), .ram_r(ram_r), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_w) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int i);
        return {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};
    endfunction

    task automatic set_word(input int i, input logic [31:0] v);
        mem[i] = v;
        for (int j = 0; j < 4; j++) ref_b[4*i+j] = 8'((v >> (8*(3-j))) & 32'hFF);
    endtask

    function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
        bit bad;
        bad = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`ifdef MAU_RANGE_CHECK_EN
        if (a >= 32'd512) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        int unsigned p, v;
        p = a % 512;
        if (sz == 2'd0) begin
            v = ref_b[p];
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = ref_b[p] * 256 + ref_b[p+1];
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = ((ref_b[p] * 256 + ref_b[p+1]) * 256 + ref_b[p+2]) * 256 + ref_b[p+3];
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned p, n;
        p = a % 512;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int j = 0; j < n; j++) ref_b[p+j] = 8'((d >> (8*(n-1-j))) & 32'hFF);
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        int k, nw, nr, exp_lat;
        bit got, bad;
        logic [31:0] exp_rd;
        bad = ref_bad(sz, a);
        k = 0;
        while (!ready && k < 20) begin @(negedge clk); k++; end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        k = 0; nw = 0; nr = 0; got = 1'b0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            nw += int'(ram_w);
            nr += int'(ram_r);
            if (done) got = 1'b1;
            else req = 1'($urandom);
        end
        req = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        if (bad) begin
            exp_rd = 32'd0;
            check({tag, "_lat_err"}, 32'(k <= 2), 32'd1);
            check({tag, "_ramw"}, 32'(nw), 32'd0);
            check({tag, "_ramr"}, 32'(nr), 32'd0);
        end else if (!w) begin
            exp_rd = ref_load(a, sz, sx);
            check({tag, "_lat"}, 32'(k), 32'd2);
            check({tag, "_ramw"}, 32'(nw), 32'd0);
        end else begin
            exp_rd = 32'd0;
            ref_store(a, sz, wd);
            exp_lat = (sz == 2'd2) ? 2 : 3;
            check({tag, "_lat"}, 32'(k), 32'(exp_lat));
            check({tag, "_ramw"}, 32'(nw), 32'd1);
        end
        check({tag, "_err"}, 32'(err), 32'(bad));
        check({tag, "_rdata"}, rdata, exp_rd);
        last_rdata = rdata;
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, done, ready}, 32'd1);
        if (w && !bad) check({tag, "_mem"}, mem[(a % 512) / 4], ref_word(int'((a % 512) / 4)));
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        for (int i = 0; i < 128; i++) set_word(i, $urandom);
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_outs", {28'd0, done, err, ram_w, ram_r}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ramaddr", 32'(ram_addr), 32'd0);
        check("rst_ramwdata", ram_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_word(3, 32'h8899AABB);
        do_req("lb", 1'b0, 2'd0, 1'b1, 32'h0C, 32'd0);
        check("lb_const", last_rdata, 32'hFFFFFF88);
        do_req("lbu", 1'b0, 2'd0, 1'b0, 32'h0F, 32'd0);
        check("lbu_const", last_rdata, 32'h000000BB);
        do_req("lh", 1'b0, 2'd1, 1'b1, 32'h0E, 32'd0);
        check("lh_const", last_rdata, 32'hFFFFAABB);
        do_req("lhu", 1'b0, 2'd1, 1'b0, 32'h0C, 32'd0);
        check("lhu_const", last_rdata, 32'h00008899);
        do_req("sb", 1'b1, 2'd0, 1'b0, 32'h0D, 32'h12);
        check("sb_word", mem[3], 32'h8812AABB);
        do_req("lw", 1'b0, 2'd2, 1'b0, 32'h0C, 32'd0);
        check("lw_const", last_rdata, 32'h8812AABB);
        do_req("sw_mis", 1'b1, 2'd2, 1'b0, 32'h0E, 32'hCAFEF00D);
        do_req("sz11", 1'b1, 2'd3, 1'b0, 32'h0C, 32'hCAFEF00D);
        check("err_word", mem[3], 32'h8812AABB);
        do_req("wrap", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
`ifdef MAU_RANGE_CHECK_EN
        check("wrap_const", last_rdata, 32'd0);
`else
        check("wrap_const", last_rdata, ref_word(0));
`endif

        // abort a word store in its write cycle
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h10; wdata = 32'hDEADBEEF;
        @(posedge clk); #2;
        req = 1'b0;
        check("rst_pre_w", 32'(ram_w), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_w", {29'd0, ram_w, ram_r, done}, 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_addr", 32'(ram_addr), 32'd0);
        check("rst_mid_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (4) begin @(negedge clk); done_seen += int'(done); end
        check("rst_no_done", 32'(done_seen), 32'd0);
        check("rst_word4", mem[4], ref_word(4));
        do_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);

        for (int t = 0; t < 150; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 511));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a = a & ~32'd1;
                else if (sz == 2'd2) a = a & ~32'd3;
                else a = a;
            end
            d = $urandom;
            do_req("rnd", 1'($urandom), sz, 1'($urandom), a, d);
        end
        for (int i = 0; i < 128; i++) check("final_mem", mem[i], ref_word(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
